// File: rtl/frenzy_input_pkg.sv
// Shared constants, types and the SOCD step function
// for the frenzy player-input conditioning stage.
package frenzy_input_pkg;

   localparam logic [7:0] KEY_UP     = 8'h75;
   localparam logic [7:0] KEY_DOWN   = 8'h72;
   localparam logic [7:0] KEY_LEFT   = 8'h6B;
   localparam logic [7:0] KEY_RIGHT  = 8'h74;
   localparam logic [7:0] KEY_SPACE  = 8'h29;
   localparam logic [7:0] KEY_ALT    = 8'h11;
   localparam logic [7:0] KEY_CTRL   = 8'h14;
   localparam logic [7:0] KEY_START1 = 8'h05;
   localparam logic [7:0] KEY_START2 = 8'h06;
   localparam logic [7:0] KEY_ESC    = 8'h76;

   localparam int JOY_R     = 0;
   localparam int JOY_L     = 1;
   localparam int JOY_D     = 2;
   localparam int JOY_U     = 3;
   localparam int JOY_FIRE  = 4;
   localparam int JOY_BOMB  = 5;
   localparam int JOY_COIN  = 6;
   localparam int JOY_START = 7;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      WAIT_REL
   } coin_state_t;

   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
      logic fire;
      logic bomb;
      logic start1;
      logic start2;
      logic coin;
   } keys_t;

   typedef struct packed {
      logic last;
      logic tie;
      logic out_a;
      logic out_b;
   } socd_t;

   // last: 0 favours a (up/left), 1 favours b (down/right)
   function automatic socd_t socd_step(
      input logic a,
      input logic b,
      input logic prev_a,
      input logic prev_b,
      input logic last,
      input logic tie
   );
      socd_t r;
      logic rise_a;
      logic rise_b;
      rise_a = a & ~prev_a;
      rise_b = b & ~prev_b;
      r.last = last;
      r.tie = tie;
      if (rise_a && rise_b) begin
         r.tie = 1'b1;
      end else if (rise_a) begin
         r.last = 1'b0;
         r.tie = 1'b0;
      end else if (rise_b) begin
         r.last = 1'b1;
         r.tie = 1'b0;
      end
      if (!(a && b)) begin
         r.tie = 1'b0;
      end
      if (a && b) begin
         r.out_a = ~r.tie & ~r.last;
         r.out_b = ~r.tie & r.last;
      end else begin
         r.out_a = a;
         r.out_b = b;
      end
      return r;
   endfunction

endpackage

// File: rtl/input_pulse_stretcher.sv
// Coin shaper: one fixed-width pulse per press,
// re-armed only after the trigger is released.
module input_pulse_stretcher
   import frenzy_input_pkg::*;
#(
   parameter int COIN_CYCLES = 200000,
   parameter int CNT_W       = 18
) (
   input  logic clock_10,
   input  logic reset,
   input  logic trigger,
   output logic pulse
);

   localparam logic [CNT_W-1:0] LOAD = CNT_W'(COIN_CYCLES - 1);

   coin_state_t state;
   coin_state_t state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic pulse_n;

   always_ff @(posedge clock_10) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         pulse <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         pulse <= pulse_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n = cnt;
      pulse_n = pulse;
      unique case (state)
         IDLE: begin
            if (trigger) begin
               state_n = PULSE;
               cnt_n = LOAD;
               pulse_n = 1'b1;
            end
         end
         PULSE: begin
            if (cnt != '0) begin
               cnt_n = cnt - 1'b1;
            end else begin
               pulse_n = 1'b0;
               state_n = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (!trigger) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            pulse_n = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/frenzy_input_ctrl.sv
// Player-input conditioning: PS/2 key latches, joystick merge,
// SOCD resolution and coin shaping ahead of the frenzy core.
module frenzy_input_ctrl
   import frenzy_input_pkg::*;
#(
   parameter int COIN_CYCLES = 200000,
   parameter int CNT_W       = 18
) (
   input  logic       clock_10,
   input  logic       reset,
   input  logic       key_strobe,
   input  logic       key_pressed,
   input  logic       key_extended,
   input  logic [7:0] key_code,
   input  logic [7:0] joystick_0,
   input  logic [7:0] joystick_1,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic       fire,
   output logic       bomb,
   output logic       start1,
   output logic       start2,
   output logic       coin
);

   keys_t keys;
   keys_t raw;
   logic [7:0] joy;

   always_ff @(posedge clock_10) begin
      if (reset) begin
         keys <= '0;
      end else if (key_strobe) begin
         if (key_extended) begin
            case (key_code)
               KEY_UP:    keys.up <= key_pressed;
               KEY_DOWN:  keys.down <= key_pressed;
               KEY_LEFT:  keys.left <= key_pressed;
               KEY_RIGHT: keys.right <= key_pressed;
               default: ;
            endcase
         end else begin
            // ALT and CTRL share the bomb latch; last event wins
            case (key_code)
               KEY_SPACE:  keys.fire <= key_pressed;
               KEY_ALT:    keys.bomb <= key_pressed;
               KEY_CTRL:   keys.bomb <= key_pressed;
               KEY_START1: keys.start1 <= key_pressed;
               KEY_START2: keys.start2 <= key_pressed;
               KEY_ESC:    keys.coin <= key_pressed;
               default: ;
            endcase
         end
      end
   end

   assign joy = joystick_0 | joystick_1;

   always_comb begin
      raw.up = keys.up | joy[JOY_U];
      raw.down = keys.down | joy[JOY_D];
      raw.left = keys.left | joy[JOY_L];
      raw.right = keys.right | joy[JOY_R];
      raw.fire = keys.fire | joy[JOY_FIRE];
      raw.bomb = keys.bomb | joy[JOY_BOMB];
      raw.start1 = keys.start1 | joy[JOY_START];
      raw.start2 = keys.start2;
      raw.coin = keys.coin | joy[JOY_COIN];
   end

   logic prev_up;
   logic prev_down;
   logic prev_left;
   logic prev_right;
   logic last_v;
   logic tie_v;
   logic last_h;
   logic tie_h;
   socd_t v;
   socd_t h;

   always_comb begin
      v = socd_step(raw.up, raw.down, prev_up, prev_down, last_v, tie_v);
      h = socd_step(raw.left, raw.right, prev_left, prev_right,
                    last_h, tie_h);
   end

   always_ff @(posedge clock_10) begin
      if (reset) begin
         prev_up <= 1'b0;
         prev_down <= 1'b0;
         prev_left <= 1'b0;
         prev_right <= 1'b0;
         last_v <= 1'b0;
         tie_v <= 1'b0;
         last_h <= 1'b0;
         tie_h <= 1'b0;
         up <= 1'b0;
         down <= 1'b0;
         left <= 1'b0;
         right <= 1'b0;
         fire <= 1'b0;
         bomb <= 1'b0;
         start1 <= 1'b0;
         start2 <= 1'b0;
      end else begin
         prev_up <= raw.up;
         prev_down <= raw.down;
         prev_left <= raw.left;
         prev_right <= raw.right;
         last_v <= v.last;
         tie_v <= v.tie;
         last_h <= h.last;
         tie_h <= h.tie;
         up <= v.out_a;
         down <= v.out_b;
         left <= h.out_a;
         right <= h.out_b;
         fire <= raw.fire;
         bomb <= raw.bomb;
         start1 <= raw.start1;
         start2 <= raw.start2;
      end
   end

   input_pulse_stretcher #(
      .COIN_CYCLES(COIN_CYCLES),
      .CNT_W(CNT_W)
   ) u_coin (
      .clock_10(clock_10),
      .reset(reset),
      .trigger(raw.coin),
      .pulse(coin)
   );

endmodule
